sio_bus_arbiter: RTL and testbench
==================================

# sio_bus_arbiter

Arbiter that shares the single quad-SPI pad group (sio0..sio3) between the PSRAM controller (master 0, chip select ce0, sclk_ram) and the NOR flash controller (master 1, chip select ce1, sclk_nor). It sits between both memory controllers and the pad wiring of the SoC top. It grants the bus to one master at a time and inserts a bus-release turnaround between owners. Chip selects of non-owners are held inactive.

## Interface
Parameters:
- TURN_CYCLES, 2, idle cycles between owners; legal range 1..15.
- MAX_HOLD, 4096, grant-duration limit in cycles; used only with SIO_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- req  in  2  bus request; bit 0 is PSRAM, bit 1 is NOR.
- gnt  out  2  registered one-hot-or-zero grant.
- m0_ce_n, m1_ce_n  in  1 each  master chip select, active-low.
- m0_sclk, m1_sclk  in  1 each  master serial clock.
- m0_sio_o, m1_sio_o  in  4 each  master output data.
- m0_sio_oe, m1_sio_oe  in  4 each  master output enables.
- ce0, ce1  out  1 each  pad chip selects, active-low.
- sclk_ram, sclk_nor  out  1 each  pad serial clocks.
- sio_o  out  4  pad output data.
- sio_oe  out  4  pad output enables.
- busy  out  1  high when state is not IDLE.
- timeout_err  out  1  one-cycle pulse on a forced release. This port exists only with SIO_ARB_TIMEOUT_EN.

Pad input data (sio_i) bypasses this block and goes to both masters.

## Operation
- States: IDLE, OWN0, OWN1, TURN.
- Output mux:
  - The mux is combinational, driven from the registered state.
  - In OWNn: ce(n), sclk(n), sio_o and sio_oe come from master n.
  - The non-owner's ce is forced to 1 and its sclk is forced to 0.
  - In IDLE and TURN: ce0 = ce1 = 1, both sclk = 0, sio_oe = 0, sio_o = 0.
- IDLE: if any eligible req is high, go to OWNn and set gnt[n].
- Tie-break is round-robin:
  - When both masters request, the master not recorded in last_gnt wins.
  - last_gnt updates on every grant.
- OWNn: stay while req[n] is high. When req[n] goes low, go to TURN and clear gnt.
- The other master's request never pre-empts the owner.
- TURN:
  - A counter loads TURN_CYCLES-1 and decrements each cycle.
  - At 0, arbitrate as in IDLE and go directly to OWNx, or to IDLE if no request is pending.
- A request that rises during TURN is served at the end of TURN. It is not served earlier.

## Timing
- Reset values (asynchronous, on resetn = 0):
  - state = IDLE, gnt = 0, last_gnt = 1 (so PSRAM wins the first tie).
  - ce0 = ce1 = 1, sclk_ram = sclk_nor = 0, sio_oe = 0, sio_o = 0.
  - busy = 0, timeout_err = 0, lockout = 0.
- Reset mid-transaction: the bus is released immediately with no turnaround.
- Grant latency: req sampled high in IDLE gives gnt high on the next rising edge. The bus mux switches in the same cycle as gnt.
- Release: req low at edge k gives gnt = 0 and bus idle from edge k+1 for exactly TURN_CYCLES cycles. The next gnt asserts at edge k+1+TURN_CYCLES.
- Back-to-back requests by the same master still pay the TURN cycles.
- Masters must keep m*_ce_n high until they see their gnt. The arbiter masks them regardless.

## Configuration
- SIO_ARB_TIMEOUT_EN defined:
  - A hold counter runs in OWNn and clears on entry to OWNn.
  - When it reaches MAX_HOLD-1 with req[n] still high:
    - force TURN, clear gnt[n], pulse timeout_err for 1 cycle, and set lockout[n].
  - lockout[n] makes req[n] ineligible until req[n] is sampled low, which clears lockout[n].
- SIO_ARB_TIMEOUT_EN undefined:
  - There is no hold counter, no lockout and no timeout_err port. Grants are unbounded.

## Test plan
- Reset, then req = 01 → gnt = 01 after 1 edge; ce0 follows m0_ce_n; ce1 = 1; sclk_nor = 0.
- req = 11 from reset → gnt = 01. Drop req[0] → 2 idle cycles (TURN_CYCLES = 2) with sio_oe = 0 → gnt = 10. Drop req[1] and raise req[0] → 01 after turnaround.
- m1 holds req[1] while req[0] toggles → no pre-emption. gnt stays 10 and ce0 stays 1 for the whole grant.
- Assert resetn = 0 mid-OWN1 with m1_sio_oe = 1111 → sio_oe = 0000, ce1 = 1 and gnt = 00 asynchronously, before the next edge.
- With SIO_ARB_TIMEOUT_EN and MAX_HOLD = 16, hold req[0] → gnt drops after 16 cycles, timeout_err pulses once, and req[0] is ignored until it is deasserted for one cycle.
- Without the macro, the same stimulus holds the grant for 1000 cycles; gnt stays 01 throughout.

Source files
------------

// File: rtl/sio_bus_arbiter.sv
// sio_bus_arbiter
//   Shares the quad-SPI pad group between the PSRAM controller (master 0)
//   and the NOR flash controller (master 1). One owner at a time, with a
//   bus-release turnaround of TURN_CYCLES idle cycles between owners.
//   Round-robin tie-break; the owner is never pre-empted by the other master.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   req[1:0]             bus requests (bit 0 PSRAM, bit 1 NOR)
//   gnt[1:0]             registered one-hot-or-zero grant
//   m0_* / m1_*          master chip select, sclk, sio data and enables
//   ce0, ce1             pad chip selects (active-low)
//   sclk_ram, sclk_nor   pad serial clocks
//   sio_o, sio_oe        pad data and output enables
//   busy                 state is not IDLE
//   timeout_err          one-cycle pulse on a forced release (macro only)
//
// Optional feature macro: SIO_ARB_TIMEOUT_EN
//   Bounds each grant to MAX_HOLD cycles; an over-holding master is forced
//   off and locked out until it drops its request.

module sio_bus_arbiter #(
    parameter int TURN_CYCLES = 2,
    parameter int MAX_HOLD    = 4096
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic       m0_ce_n,
    input  logic       m1_ce_n,
    input  logic       m0_sclk,
    input  logic       m1_sclk,
    input  logic [3:0] m0_sio_o,
    input  logic [3:0] m1_sio_o,
    input  logic [3:0] m0_sio_oe,
    input  logic [3:0] m1_sio_oe,
    output logic       ce0,
    output logic       ce1,
    output logic       sclk_ram,
    output logic       sclk_nor,
    output logic [3:0] sio_o,
    output logic [3:0] sio_oe,
    output logic       busy
`ifdef SIO_ARB_TIMEOUT_EN
    ,
    output logic       timeout_err
`endif
);

    if (TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_bad_turn
        $error("sio_bus_arbiter: TURN_CYCLES must be 1..15");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("sio_bus_arbiter: MAX_HOLD must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_t;

    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

    state_t     state;
    logic       last_gnt;    // index of the most recent grant
    logic [3:0] turn_cnt;
    logic [1:0] elig;
    logic       pick_valid;
    logic       pick;        // index of the winner when pick_valid
    logic       own_idx;
    logic       own_req;

`ifdef SIO_ARB_TIMEOUT_EN
    localparam int              HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        lockout;

    assign elig = req & ~lockout;
`else
    assign elig = req;
`endif

    // On a tie the master that did not own the bus last wins.
    always_comb begin
        pick_valid = |elig;
        if (&elig) pick = ~last_gnt;
        else       pick = elig[1];
    end

    assign own_idx = (state == OWN1);
    assign own_req = own_idx ? req[1] : req[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            last_gnt <= 1'b1;
            turn_cnt <= 4'd0;
`ifdef SIO_ARB_TIMEOUT_EN
            hold_cnt    <= '0;
            lockout     <= 2'b00;
            timeout_err <= 1'b0;
`endif
        end else begin
`ifdef SIO_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
            // A locked-out master is forgiven once its request is seen low.
            lockout     <= lockout & req;
`endif
            case (state)
                IDLE, TURN: begin
                    if (state == TURN && turn_cnt != 4'd0) begin
                        turn_cnt <= turn_cnt - 4'd1;
                    end else if (pick_valid) begin
                        state    <= pick ? OWN1 : OWN0;
                        gnt      <= pick ? 2'b10 : 2'b01;
                        last_gnt <= pick;
`ifdef SIO_ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin // OWN0, OWN1
                    if (!own_req) begin
                        state    <= TURN;
                        gnt      <= 2'b00;
                        turn_cnt <= TURN_LOAD;
`ifdef SIO_ARB_TIMEOUT_EN
                    end else if (hold_cnt == HOLD_LAST) begin
                        state             <= TURN;
                        gnt               <= 2'b00;
                        turn_cnt          <= TURN_LOAD;
                        timeout_err       <= 1'b1;
                        lockout[own_idx]  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
`endif
                    end
                end
            endcase
        end
    end

    // Pad mux decoded from the registered state, so it switches with gnt
    // and drops to idle the instant reset asserts.
    always_comb begin
        ce0      = 1'b1;
        ce1      = 1'b1;
        sclk_ram = 1'b0;
        sclk_nor = 1'b0;
        sio_o    = 4'h0;
        sio_oe   = 4'h0;
        case (state)
            OWN0: begin
                ce0      = m0_ce_n;
                sclk_ram = m0_sclk;
                sio_o    = m0_sio_o;
                sio_oe   = m0_sio_oe;
            end
            OWN1: begin
                ce1      = m1_ce_n;
                sclk_nor = m1_sclk;
                sio_o    = m1_sio_o;
                sio_oe   = m1_sio_oe;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sio_bus_arbiter.sv
// Directed bench for sio_bus_arbiter (TURN_CYCLES = 2, MAX_HOLD = 16).
// Each step drives req, queues the expected bus owner for the next edge and
// compares every pad output against what that owner implies.

module tb_sio_bus_arbiter;

    localparam int O0 = 0, O1 = 1, IDL = 2, TRN = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] gnt;
    logic       m0_ce_n = 1'b0, m1_ce_n = 1'b0;
    logic       m0_sclk = 1'b1, m1_sclk = 1'b1;
    logic [3:0] m0_sio_o = 4'hA, m1_sio_o = 4'h5;
    logic [3:0] m0_sio_oe = 4'hF, m1_sio_oe = 4'hF;
    logic       ce0, ce1, sclk_ram, sclk_nor, busy;
    logic [3:0] sio_o, sio_oe;
`ifdef SIO_ARB_TIMEOUT_EN
    logic       timeout_err;
`endif

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int    own;
        string tag;
    } exp_t;
    exp_t exp_q[$];

    sio_bus_arbiter #(.TURN_CYCLES(2), .MAX_HOLD(16)) dut (
        .clk(clk), .resetn(resetn), .req(req), .gnt(gnt),
        .m0_ce_n(m0_ce_n), .m1_ce_n(m1_ce_n),
        .m0_sclk(m0_sclk), .m1_sclk(m1_sclk),
        .m0_sio_o(m0_sio_o), .m1_sio_o(m1_sio_o),
        .m0_sio_oe(m0_sio_oe), .m1_sio_oe(m1_sio_oe),
        .ce0(ce0), .ce1(ce1), .sclk_ram(sclk_ram), .sclk_nor(sclk_nor),
        .sio_o(sio_o), .sio_oe(sio_oe), .busy(busy)
`ifdef SIO_ARB_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected pad picture for a given owner, built from the current master inputs.
    task automatic check_bus(input int own, input string tag);
        logic [14:0] e;
        logic [1:0]  g_e;
        g_e = (own == O0) ? 2'b01 : (own == O1) ? 2'b10 : 2'b00;
        e = {g_e,
             (own == O0) ? m0_ce_n : 1'b1,
             (own == O1) ? m1_ce_n : 1'b1,
             (own == O0) ? m0_sclk : 1'b0,
             (own == O1) ? m1_sclk : 1'b0,
             (own == O0) ? m0_sio_o : (own == O1) ? m1_sio_o : 4'h0,
             (own == O0) ? m0_sio_oe : (own == O1) ? m1_sio_oe : 4'h0,
             own != IDL};
        chk(tag, {17'd0, gnt, ce0, ce1, sclk_ram, sclk_nor, sio_o, sio_oe, busy}, {17'd0, e});
    endtask

    task automatic step(input logic [1:0] r, input int own, input string tag);
        exp_t e;
        req       = r;
        m0_sio_o  = 4'($urandom_range(0, 15));
        m1_sio_o  = 4'($urandom_range(0, 15));
        m0_sio_oe = 4'($urandom_range(1, 15));
        exp_q.push_back('{own, tag});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_bus(e.own, e.tag);
    endtask

    initial begin
        // Reset with active-looking master inputs: everything must be masked.
        #1;
        check_bus(IDL, "reset");
        step(2'b11, IDL, "reset_hold");
        resetn = 1'b1;

        // Single grant to PSRAM, ce0 follows master, then release + turnaround.
        step(2'b01, O0, "grant0");
        step(2'b01, O0, "own0_hold");
        m0_ce_n = 1'b1;
        #1;
        check_bus(O0, "ce0_follow_hi");
        m0_ce_n = 1'b0;
        #1;
        check_bus(O0, "ce0_follow_lo");
        step(2'b00, TRN, "rel0_turn1");
        step(2'b00, TRN, "rel0_turn2");
        step(2'b00, IDL, "rel0_idle");

        // Back-to-back by the same master still pays the turnaround.
        step(2'b01, O0, "b2b_grant");
        step(2'b00, TRN, "b2b_turn1");
        step(2'b01, TRN, "b2b_turn2");
        step(2'b01, O0, "b2b_regrant");

        // Fresh reset so last_gnt is back at its reset value.
        resetn = 1'b0;
        #1;
        check_bus(IDL, "rst_async_own0");
        resetn = 1'b1;

        // Tie from reset goes to PSRAM; NOR follows after turnaround.
        step(2'b11, O0, "tie_first0");
        step(2'b11, O0, "tie_hold0");
        step(2'b10, TRN, "hand_turn1");
        step(2'b10, TRN, "hand_turn2");
        step(2'b10, O1, "hand_own1");
        // req[0] toggling never pre-empts NOR.
        step(2'b11, O1, "nopre_a");
        step(2'b10, O1, "nopre_b");
        step(2'b11, O1, "nopre_c");
        step(2'b11, O1, "nopre_d");
        // NOR drops, PSRAM waiting: served only after the turnaround.
        step(2'b01, TRN, "swap_turn1");
        step(2'b01, TRN, "swap_turn2");
        step(2'b01, O0, "swap_own0");
        // Round robin: tie at end of turn after PSRAM owned -> NOR.
        step(2'b00, TRN, "rr_turn1");
        step(2'b11, TRN, "rr_turn2");
        step(2'b11, O1, "rr_win1");
        // Tie after NOR owned -> PSRAM.
        step(2'b01, TRN, "rr_turn3");
        step(2'b11, TRN, "rr_turn4");
        step(2'b11, O0, "rr_win0");
        step(2'b10, TRN, "rr_turn5");
        step(2'b10, TRN, "rr_turn6");
        step(2'b10, O1, "own1_pre_rst");

        // Reset mid-OWN1 with all enables on: released before the next edge.
        m1_sio_oe = 4'hF;
        #1;
        check_bus(O1, "own1_oe_full");
        resetn = 1'b0;
        #1;
        check_bus(IDL, "rst_async_own1");
        step(2'b10, IDL, "rst_held");
        resetn = 1'b1;

        // Long hold by PSRAM.
        step(2'b01, O0, "hold_grant");
`ifdef SIO_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            step(2'b01, O0, "hold_pre_to");
            chk("to_err_quiet", 32'(timeout_err), 32'd0);
        end
        step(2'b01, TRN, "to_forced_turn1");
        chk("to_err_pulse", 32'(timeout_err), 32'd1);
        step(2'b01, TRN, "to_forced_turn2");
        chk("to_err_single", 32'(timeout_err), 32'd0);
        step(2'b01, IDL, "to_locked_a");
        step(2'b01, IDL, "to_locked_b");
        step(2'b00, IDL, "to_unlock");
        step(2'b01, O0, "to_regrant");
        chk("to_err_after", 32'(timeout_err), 32'd0);
`else
        for (int i = 0; i < 1000; i++) begin
            step(2'b01, O0, "hold_unbounded");
        end
`endif
        step(2'b00, TRN, "final_turn1");
        step(2'b00, TRN, "final_turn2");
        step(2'b00, IDL, "final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
